// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: fetches from a combinational ROM and buffers PC-tagged words for decode.
// Optional macro INSTR_PREFETCH_BYPASS_EN forwards the ROM word straight to decode when the queue is empty.
module instr_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] PC_STEP  = 64'd4,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic [63:0]                rom_addr,
    input  logic [31:0]                rom_data,
    input  logic                       redirect,
    input  logic [63:0]                redirect_pc,
    output logic                       out_valid,
    output logic [31:0]                out_instr,
    output logic [63:0]                out_pc,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, FULL} state_t;

    state_t             state;
    state_t             stateNext;
    logic [PTR_W-1:0]   wrPtr;
    logic [PTR_W-1:0]   rdPtr;
    logic [CNT_W-1:0]   countQ;
    logic [CNT_W-1:0]   countNext;
    logic [63:0]        fetchPc;
    logic [31:0]        instrMem [DEPTH];
    logic [63:0]        pcMem    [DEPTH];

    logic headValid;
    logic bypassActive;
    logic qPop;
    logic canPush;
    logic push;

    assign headValid = (countQ != '0);

`ifdef INSTR_PREFETCH_BYPASS_EN
    assign bypassActive = (countQ == '0) && (state == RUN) && !redirect;
`else
    assign bypassActive = 1'b0;
`endif

    always_comb begin
        stateNext = state;
        qPop      = headValid && out_ready;
        canPush   = !redirect && ((state == RUN) || ((state == FULL) && qPop));
        // A bypassed word consumed this cycle never enters the queue.
        push      = canPush && !(bypassActive && out_ready);
        countNext = countQ;
        case ({push, qPop})
            2'b10:   countNext = countQ + 1'b1;
            2'b01:   countNext = countQ - 1'b1;
            default: countNext = countQ;
        endcase
        if (redirect) begin
            stateNext = RUN;
        end else if (state == IDLE) begin
            stateNext = RUN;
        end else begin
            stateNext = (countNext == FULL_CNT) ? FULL : RUN;
        end

        out_valid = headValid || bypassActive;
        out_instr = 32'h0;
        out_pc    = 64'h0;
        if (headValid) begin
            out_instr = instrMem[rdPtr];
            out_pc    = pcMem[rdPtr];
        end else if (bypassActive) begin
            out_instr = rom_data;
            out_pc    = fetchPc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            countQ  <= '0;
            wrPtr   <= '0;
            rdPtr   <= '0;
            fetchPc <= RESET_PC;
        end else if (redirect) begin
            countQ  <= '0;
            wrPtr   <= '0;
            rdPtr   <= '0;
            fetchPc <= redirect_pc;
        end else begin
            countQ <= countNext;
            if (push) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (qPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            if (canPush) begin
                fetchPc <= fetchPc + PC_STEP;
            end
        end
    end

    // Queue storage carries no reset; only occupied entries are ever observed.
    always_ff @(posedge clk) begin
        if (push) begin
            instrMem[wrPtr] <= rom_data;
            pcMem[wrPtr]    <= fetchPc;
        end
    end

    assign rom_addr = fetchPc;
    assign count    = countQ;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for instr_prefetch_queue (default build, DEPTH=4, ROM word = address).
module tb_instr_prefetch_queue;

    logic        clk;
    logic        rst;
    logic [63:0] romAddr;
    logic [31:0] romData;
    logic        redirect;
    logic [63:0] redirectPc;
    logic        outValid;
    logic [31:0] outInstr;
    logic [63:0] outPc;
    logic        outReady;
    logic [2:0]  count;

    int nAssert = 0;
    int nFail   = 0;

    instr_prefetch_queue #(.DEPTH(4), .PC_STEP(64'd4), .RESET_PC(64'h0)) dut (
        .clk        (clk),
        .rst        (rst),
        .rom_addr   (romAddr),
        .rom_data   (romData),
        .redirect   (redirect),
        .redirect_pc(redirectPc),
        .out_valid  (outValid),
        .out_instr  (outInstr),
        .out_pc     (outPc),
        .out_ready  (outReady),
        .count      (count)
    );

    assign romData = romAddr[31:0];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst        = 1'b0;
        redirect   = 1'b0;
        redirectPc = 64'h0;
        outReady   = 1'b0;
        #2;
        chk("rst_valid", {63'h0, outValid}, 64'h0);
        chk("rst_count", {61'h0, count}, 64'h0);
        chk("rst_addr", romAddr, 64'h0);
        chk("rst_instr", {32'h0, outInstr}, 64'h0);
        chk("rst_pc", outPc, 64'h0);
        @(negedge clk);
        @(negedge clk);
        rst      = 1'b1;
        outReady = 1'b1;

        // Streaming from reset
        step();
        chk("idle_valid", {63'h0, outValid}, 64'h0);
        chk("idle_count", {61'h0, count}, 64'h0);
        chk("idle_addr", romAddr, 64'h0);
        step();
        chk("first_valid", {63'h0, outValid}, 64'h1);
        chk("first_pc", outPc, 64'h0);
        chk("first_count", {61'h0, count}, 64'h1);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("stream_pc", outPc, 64'(4 * k));
            chk("stream_instr", {32'h0, outInstr}, 64'(4 * k));
            chk("stream_count", {61'h0, count}, 64'h1);
        end
        chk("stream_addr", romAddr, 64'd20);

        // Fill to full with decode stalled
        outReady   = 1'b0;
        redirect   = 1'b1;
        redirectPc = 64'h0;
        step();
        redirect = 1'b0;
        chk("fill_flush_count", {61'h0, count}, 64'h0);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("fill_count", {61'h0, count}, 64'(k));
        end
        chk("fill_addr", romAddr, 64'd16);
        chk("fill_head", outPc, 64'h0);
        step();
        chk("full_hold_count", {61'h0, count}, 64'd4);
        chk("full_hold_addr", romAddr, 64'd16);
        chk("full_hold_head", outPc, 64'h0);

        // Drain while full: one push per pop
        outReady = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            chk("drain_pc", outPc, 64'(4 * k));
            chk("drain_instr", {32'h0, outInstr}, 64'(4 * k));
            chk("drain_count", {61'h0, count}, 64'd4);
            chk("drain_addr", romAddr, 64'(16 + 4 * k));
        end

        // Redirect with three entries queued
        outReady   = 1'b0;
        redirect   = 1'b1;
        redirectPc = 64'h200;
        step();
        redirect = 1'b0;
        step();
        step();
        step();
        chk("pre_redir_count", {61'h0, count}, 64'd3);
        chk("pre_redir_head", outPc, 64'h200);
        redirect   = 1'b1;
        redirectPc = 64'h100;
        step();
        redirect = 1'b0;
        outReady = 1'b1;
        chk("redir_count", {61'h0, count}, 64'h0);
        chk("redir_valid", {63'h0, outValid}, 64'h0);
        chk("redir_addr", romAddr, 64'h100);
        step();
        chk("redir_pc0", outPc, 64'h100);
        chk("redir_valid1", {63'h0, outValid}, 64'h1);
        step();
        chk("redir_pc1", outPc, 64'h104);

        // PC wrap-around at the top of the address space
        redirect   = 1'b1;
        redirectPc = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        redirect = 1'b0;
        chk("wrap_addr0", romAddr, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_empty_pop", {61'h0, count}, 64'h0);
        step();
        chk("wrap_pc0", outPc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_instr0", {32'h0, outInstr}, 64'hFFFF_FFFC);
        chk("wrap_addr1", romAddr, 64'h0);
        step();
        chk("wrap_pc1", outPc, 64'h0);
        chk("wrap_addr2", romAddr, 64'h4);

        // Asynchronous reset mid-fill
        outReady   = 1'b0;
        redirect   = 1'b1;
        redirectPc = 64'h40;
        step();
        redirect = 1'b0;
        step();
        step();
        chk("mid_count", {61'h0, count}, 64'd2);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_count", {61'h0, count}, 64'h0);
        chk("arst_valid", {63'h0, outValid}, 64'h0);
        chk("arst_addr", romAddr, 64'h0);
        @(negedge clk);
        rst = 1'b1;
        step();
        chk("rel_idle_valid", {63'h0, outValid}, 64'h0);
        chk("rel_idle_addr", romAddr, 64'h0);
        step();
        chk("rel_valid", {63'h0, outValid}, 64'h1);
        chk("rel_pc", outPc, 64'h0);
        chk("rel_addr", romAddr, 64'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule

// File: doc/instr_prefetch_queue.md
# instr_prefetch_queue

Instruction prefetch buffer sitting between the instruction ROM and the ControlUnit. It drives the ROM address, captures the 32-bit instruction words that come back, and holds up to DEPTH of them in a FIFO tagged with their PC. It presents them to the decode stage with a valid/ready handshake. A redirect, taken from a branch or jump, flushes the queue and restarts fetch from a new PC, so decode never sees a wrong-path instruction after the redirect cycle.

## Interface
- DEPTH, 4, queue entries; power of two, minimum 2
- PC_STEP, 4, byte increment applied to the fetch PC after each captured word
- RESET_PC, 64'h0, fetch PC loaded on reset
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- rom_addr  output  64  fetch PC presented to the ROM (ROM read is combinational)
- rom_data  input  32  instruction word at rom_addr, valid in the same cycle
- redirect  input  1  flush the queue and restart fetch
- redirect_pc  input  64  new fetch PC, sampled when redirect=1
- out_valid  output  1  head entry is valid
- out_instr  output  32  head instruction word
- out_pc  output  64  PC of head instruction
- out_ready  input  1  decode accepts head entry this cycle
- count  output  $clog2(DEPTH)+1  number of occupied entries

## Operation
- State machine with three states:
  - IDLE: entered on reset; lasts exactly one cycle, with no push; then goes to RUN.
  - RUN: count < DEPTH.
  - FULL: count == DEPTH.
- The state machine never stays in IDLE after that first cycle.
- Pop: out_valid && out_ready.
- Push: occurs in RUN, or in FULL when a pop happens the same cycle, provided redirect=0.
  - On push, write {rom_data, fetch_pc} at the write pointer.
  - Then fetch_pc <= fetch_pc + PC_STEP, mod 2^64; wrap-around at all-ones is legal and silent.
- Simultaneous push and pop: count is unchanged, and both pointers advance.
- Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
- Redirect has priority over everything else:
  - count <= 0, pointers <= 0, fetch_pc <= redirect_pc, state <= RUN.
  - No push occurs that cycle.
  - A pop in the same cycle is still considered consumed by decode, but it has no effect on the flushed queue.
- rom_addr = fetch_pc at all times.
- out_valid = (count != 0).
- out_instr and out_pc come from the read-pointer entry and are held stable while out_valid && !out_ready.
- rst low, at any time including mid-fill:
  - Immediately clears count and pointers.
  - fetch_pc <= RESET_PC, state <= IDLE.
  - Entry contents are don't-care.

## Timing
- Reset values: out_valid=0, count=0, rom_addr=RESET_PC, out_instr=0, out_pc=0 (gated while empty).
- First push is on the second rising edge after rst is released.
- First out_valid is one cycle after that push.
- Fetch-to-output latency is 1 cycle (registered queue).
- Steady state with out_ready=1: one instruction per cycle, and count stays at 1.
- After redirect: out_valid=0 in the next cycle; the first redirect_pc instruction is valid one cycle later.
- Empty plus pop attempt: no effect, because the handshake requires out_valid.

## Configuration
- INSTR_PREFETCH_BYPASS_EN defined:
  - When count==0, state is RUN and redirect=0, rom_data/rom_addr drive out_instr/out_pc combinationally, with out_valid=1.
  - If out_ready=1, the word is consumed without being written (no push, fetch_pc still advances).
  - Otherwise it is pushed normally.
  - Redirect-to-valid latency drops to 1 cycle.
- INSTR_PREFETCH_BYPASS_EN undefined: the purely registered behaviour described above, with out_valid a flop-derived signal.

## Test plan
- Reset, then out_ready=1, ROM word = address. Required response:
  - out_pc sequence 0,4,8,12…
  - out_instr equals the low 32 bits of out_pc.
  - First out_valid is on cycle 3 after reset release.
- Fill with out_ready=0 and DEPTH=4. Required response:
  - count reaches 4 and the state is FULL.
  - rom_addr holds at 16.
  - The head stays at PC 0.
  - Asserting out_ready drains PCs 0,4,8,12,16… with no gaps.
- Full plus simultaneous pop. Required response:
  - count stays at 4.
  - Exactly one push per pop.
  - No entry is overwritten before it is read.
- Redirect to 64'h100 with 3 entries queued. Required response:
  - Next cycle: count=0 and out_valid=0.
  - The following cycle: out_pc=64'h100.
  - Stale PCs never appear at the output.
- Redirect to 64'hFFFF_FFFF_FFFF_FFFC. Required response: fetch PCs …FFFC then 64'h0; there is no error.
- Assert rst low mid-fill with count=2. Required response:
  - out_valid=0 and count=0 immediately, without waiting for a clock edge.
  - After release, fetch resumes at RESET_PC after the IDLE cycle.
